// File: rtl/rshift_seq_23.sv
// Sequential right shifter: one bit per cycle with guard/sticky capture.
// Result is held in DONE until the consumer handshakes with ready.
module rshift_seq_23 #(
  parameter int W  = 23,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  num,
  input  logic [SW-1:0] shamt,
  input  logic          A1,
  input  logic          ready,
  output logic [W-1:0]  result,
  output logic          guard,
  output logic          sticky,
  output logic          valid,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SW-1:0] ONE = SW'(1);

  state_t        state, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          fill_q, fill_d;
  logic          guard_q, guard_d;
  logic          sticky_q, sticky_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_q   <= '0;
      cnt_q    <= '0;
      fill_q   <= 1'b0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state    <= state_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      fill_q   <= fill_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d  = state;
    data_d   = data_q;
    cnt_d    = cnt_q;
    fill_d   = fill_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    unique case (1'b1)
      (state == IDLE): begin
        if (start) begin
          data_d   = num;
          cnt_d    = shamt;
          fill_d   = A1;
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          state_d  = (shamt == '0) ? DONE : SHIFT;
        end
      end
      (state == SHIFT): begin
        data_d   = {fill_q, data_q[W-1:1]};
        guard_d  = data_q[0];
        sticky_d = sticky_q | guard_q;
        // counter saturates at zero; last shift happens on the 1->0 step
        if (cnt_q != '0) cnt_d = cnt_q - ONE;
        if (cnt_q <= ONE) state_d = DONE;
      end
      (state == DONE): begin
        if (ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign result = data_q;
  assign guard  = guard_q;
  assign sticky = sticky_q;
  assign valid  = (state == DONE);
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_rshift_seq_23.sv
// Randomised bench for rshift_seq_23 against a bit-extension model.
// Literal cases pin the model; a negedge process compares every cycle.
module tb_rshift_seq_23;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [22:0] num = '0;
  logic [4:0]  shamt = '0;
  logic        A1 = 1'b0;
  logic        ready = 1'b0;
  logic [22:0] result;
  logic        guard, sticky, valid, busy;

  int n_tests = 0;
  int n_fail  = 0;

  rshift_seq_23 #(.W(23), .SW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num(num), .shamt(shamt), .A1(A1), .ready(ready),
    .result(result), .guard(guard), .sticky(sticky),
    .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, got, exp, $time);
    end
  endtask

  // Shift as arithmetic on an operand extended upward with the fill bit
  function automatic logic [24:0] ref_shift(input logic [22:0] n,
                                            input int s, input logic a);
    logic [63:0] ext;
    logic g, st;
    ext = {{41{a}}, n};
    g  = (s > 0) ? ext[s-1] : 1'b0;
    st = 1'b0;
    for (int j = 0; j < s - 1; j++) st = st | ext[j];
    return {ext[s +: 23], g, st};
  endfunction

  logic        m_busy, m_valid;
  int          m_wait;
  logic [22:0] m_res, f_res;
  logic        m_g, m_st, f_g, m_sticky_f;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_wait <= 0;
      m_res <= '0; m_g <= 1'b0; m_st <= 1'b0;
      f_res <= '0; f_g <= 1'b0; m_sticky_f <= 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1;
        m_wait <= int'(shamt);
        m_res  <= num; m_g <= 1'b0; m_st <= 1'b0;
        {f_res, f_g, m_sticky_f} <= ref_shift(num, int'(shamt), A1);
        if (shamt == 0) m_valid <= 1'b1;
      end
    end else if (!m_valid) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_valid <= 1'b1;
        m_res <= f_res; m_g <= f_g; m_st <= m_sticky_f;
      end
    end else if (ready) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("valid", 32'(valid), 32'(m_valid));
    if (!(m_busy && !m_valid)) begin
      chk("result", 32'(result), 32'(m_res));
      chk("guard", 32'(guard), 32'(m_g));
      chk("sticky", 32'(sticky), 32'(m_st));
    end
  end

  task automatic noise();
    start = 1'($urandom_range(0, 1));
    num   = 23'($urandom);
    shamt = 5'($urandom);
    A1    = 1'($urandom_range(0, 1));
  endtask

  // Called #1 after a rising edge with the DUT idle
  task automatic op(input logic [22:0] n, input logic [4:0] s,
                    input logic a, input int hold,
                    output logic [22:0] r, output logic g,
                    output logic st);
    int edges;
    num = n; shamt = s; A1 = a; start = 1'b1;
    ready = (hold == 0);
    @(posedge clk); #1; start = 1'b0;
    edges = 1;
    while (!valid && edges < 100) begin
      noise();
      @(posedge clk); #1; start = 1'b0;
      edges++;
    end
    chk("latency", 32'(edges), 32'(s) + 32'd1);
    r = result; g = guard; st = sticky;
    for (int i = 0; i < hold; i++) begin
      noise();
      @(posedge clk); #1; start = 1'b0;
      chk("hold_valid", 32'(valid), 32'd1);
      chk("hold_res", 32'(result), 32'(r));
      chk("hold_gs", 32'({guard, sticky}), 32'({g, st}));
    end
    ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_hs", 32'({busy, valid}), 32'd0);
  endtask

  logic [22:0] r;
  logic        g, st;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'({busy, valid, guard, sticky}), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    rst_n = 1'b1;

    op(23'h400001, 5'd1, 1'b0, 0, r, g, st);
    chk("c1_res", 32'(r), 32'h200000);
    chk("c1_gs", 32'({g, st}), 32'b10);
    op(23'h000007, 5'd3, 1'b1, 0, r, g, st);
    chk("c2_res", 32'(r), 32'h700000);
    chk("c2_gs", 32'({g, st}), 32'b11);
    op(23'h123456, 5'd0, 1'b0, 0, r, g, st);
    chk("c3_res", 32'(r), 32'h123456);
    chk("c3_gs", 32'({g, st}), 32'b00);
    op(23'h7FFFFF, 5'd31, 1'b0, 0, r, g, st);
    chk("c4_res", 32'(r), 32'h000000);
    chk("c4_gs", 32'({g, st}), 32'b01);
    op(23'h2AAAAA, 5'd4, 1'b1, 5, r, g, st);
    chk("c5_res", 32'(r), 32'h7AAAAA);
    chk("c5_gs", 32'({g, st}), 32'b11);

    for (int k = 0; k < 40; k++)
      op(23'($urandom), 5'($urandom), 1'($urandom_range(0, 1)),
         int'($urandom_range(0, 3)), r, g, st);

    num = 23'h0F0F0F; shamt = 5'd20; A1 = 1'b1; start = 1'b1;
    ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_flags", 32'({busy, valid, guard, sticky}), 32'd0);
    chk("async_rst_res", 32'(result), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    op(23'h000010, 5'd5, 1'b0, 1, r, g, st);
    chk("post_rst_res", 32'(r), 32'h000000);
    chk("post_rst_gs", 32'({g, st}), 32'b10);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
